// File: rtl/uart_echo_pkg.sv
// Purpose: shared mode encoding, ASCII constants and the letter test for the UART echo engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    CASE_SWAP = 2'd1,
    LINE      = 2'd2,
    RSVD      = 2'd3
  } mode_e;

  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] UPPER_A = 8'h41;
  localparam logic [7:0] UPPER_Z = 8'h5A;
  localparam logic [7:0] LOWER_A = 8'h61;
  localparam logic [7:0] LOWER_Z = 8'h7A;
  localparam int         CASE_BIT = 5;

  // True for ASCII A-Z and a-z; only these bytes get their case flipped.
  function automatic logic is_alpha(input logic [7:0] b);
    return ((b >= UPPER_A) && (b <= UPPER_Z)) || ((b >= LOWER_A) && (b <= LOWER_Z));
  endfunction

endpackage

// File: rtl/uart_echo_engine_if.sv
// Purpose: rx/tx byte streams between the UART receiver, the echo engine and the transmitter.
// Ports: rx_data/rx_valid/rx_ready (into the engine), tx_data/tx_valid/tx_ready (out of the engine).
// Backpressure: valid/ready on both streams; a beat moves when valid && ready.
interface uart_echo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  // master: the UART side feeding rx and draining tx
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  // slave: the echo engine
  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_echo_engine_fifo.sv
// Purpose: generic circular buffer; ports wr_en/din/full, rd_en/dout/empty, count.
// Latency: a write is visible on dout/empty one cycle later; dout is the registered head entry.
// Backpressure: writes while full and reads while empty are ignored; the caller gates them.
module fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  // Storage is reset so the head reads as zero out of reset.
  assign dout  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_engine.sv
// Purpose: buffers UART rx bytes, optionally case-swaps them, and releases them to tx per mode
//          (LINE holds bytes until a CR or a full buffer). Ports: clk, reset, mode, bus (slave),
//          fifo_count, line_count. Latency: 1 cycle enqueue->tx_valid. Backpressure: rx_ready=!full, no bypass.
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  uart_echo_if.slave    bus,
  output logic [CW-1:0] fifo_count,
  output logic [15:0]   line_count
);

  logic             run_q;      // low during reset and the first cycle out of it
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic             is_cr;
  logic             line_mode;
  logic [WIDTH-1:0] wr_dat;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    held;       // LINE: accepted but not yet releasable
  logic [CW-1:0]    eligible;   // releasable bytes at the head of the buffer
  logic [CW-1:0]    held_nxt;
  logic [CW-1:0]    elig_nxt;

  assign line_mode    = (mode_e'(mode) == LINE);
  assign is_cr        = (bus.rx_data[7:0] == CR);
  assign bus.rx_ready = run_q && !full;
  assign bus.tx_valid = line_mode ? (eligible != '0) : !empty;
  assign enq          = bus.rx_valid && bus.rx_ready;
  assign deq          = bus.tx_valid && bus.tx_ready;
  assign count_nxt    = fifo_count + CW'(enq) - CW'(deq);

  // Case swap touches only ASCII letters in the low byte; upper bits always pass through.
  always_comb begin
    wr_dat = bus.rx_data;
    if ((mode_e'(mode) == CASE_SWAP) && is_alpha(bus.rx_data[7:0]))
      wr_dat[CASE_BIT] = ~bus.rx_data[CASE_BIT];
  end

  // Release accounting. Outside LINE everything in the buffer is releasable, which also makes
  // bytes already buffered eligible the moment LINE is entered.
  always_comb begin
    held_nxt = held;
    elig_nxt = eligible;
    if (!line_mode) begin
      held_nxt = '0;
      elig_nxt = count_nxt;
    end else begin
      if (enq) begin
        if (is_cr) begin
          elig_nxt = elig_nxt + held + CW'(1);
          held_nxt = '0;
        end else begin
          held_nxt = held + CW'(1);
        end
      end
      if (deq) elig_nxt = elig_nxt - CW'(1);
      // A full buffer with no CR would never drain; release whatever is held.
      if (count_nxt == CW'(DEPTH)) begin
        elig_nxt = elig_nxt + held_nxt;
        held_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      held       <= '0;
      eligible   <= '0;
      line_count <= '0;
    end else begin
      run_q    <= 1'b1;
      held     <= held_nxt;
      eligible <= elig_nxt;
      if (enq && is_cr) line_count <= line_count + 16'd1;
    end
  end

  fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (enq),
    .din   (wr_dat),
    .full  (full),
    .rd_en (deq),
    .dout  (bus.tx_data),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_echo_engine.sv
module tb_uart_echo_engine;
  import uart_echo_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [CW-1:0] fifo_count;
  logic [15:0]   line_count;

  uart_echo_if #(.WIDTH(8)) bus ();

  uart_echo_engine #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of stored bytes, each tagged with whether it may leave yet.
  typedef struct {
    logic [7:0] dat;
    bit         rel;
  } ent_t;

  ent_t       q[$];
  logic [7:0] out_log[$];
  int         lines;
  bit         ready_en;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] md);
    if (md == 2'd1) begin
      if (b >= 8'h41 && b <= 8'h5A) return b + 8'd32;
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
    end
    return b;
  endfunction

  function automatic bit model_vld(input logic [1:0] md);
    if (q.size() == 0) return 1'b0;
    if (md == 2'd2) return q[0].rel;
    return 1'b1;
  endfunction

  task automatic release_all();
    foreach (q[i]) q[i].rel = 1'b1;
  endtask

  // One clock: drive at negedge, check outputs, then apply the transfer to the model at posedge.
  task automatic step(input logic rv, input logic [7:0] rd, input logic tr, input logic [1:0] md);
    bit exp_rdy, exp_vld, enq, deq;
    ent_t e;
    @(negedge clk);
    bus.rx_valid = rv;
    bus.rx_data  = rd;
    bus.tx_ready = tr;
    mode         = md;
    #1;
    exp_rdy = ready_en && (q.size() < DEPTH);
    exp_vld = model_vld(md);
    chk("rx_ready", bus.rx_ready, exp_rdy);
    chk("tx_valid", bus.tx_valid, exp_vld);
    if (exp_vld) chk("tx_data", bus.tx_data, q[0].dat);
    chk("fifo_count", fifo_count, q.size());
    chk("line_count", line_count, lines & 16'hFFFF);
    enq = rv && exp_rdy;
    deq = exp_vld && tr;
    if (deq) out_log.push_back(bus.tx_data);
    @(posedge clk);
    if (deq) void'(q.pop_front());
    if (enq) begin
      e.dat = xform(rd, md);
      e.rel = 1'b0;
      q.push_back(e);
      if (rd == 8'h0D) lines++;
    end
    if (md != 2'd2) release_all();
    else if ((enq && rd == 8'h0D) || q.size() == DEPTH) release_all();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    #1;
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_rx_ready", bus.rx_ready, 1'b0);
    chk("rst_line_count", line_count, 0);
    q.delete();
    lines    = 0;
    ready_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_rdy_held", bus.rx_ready, 1'b0);
    @(posedge clk);
    ready_en = 1'b1;
  endtask

  task automatic chk_log(input string tag, input logic [31:0] exp_bytes, input int n);
    logic [31:0] v;
    chk({tag, "_n"}, out_log.size(), n);
    v = exp_bytes;
    for (int i = 0; i < n && i < out_log.size(); i++)
      chk(tag, out_log[i], v[8*(n-1-i) +: 8]);
    out_log.delete();
  endtask

  initial begin
    logic [1:0] md;
    logic [7:0] b;
    reset        = 1'b1;
    mode         = 2'd0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    lines        = 0;
    ready_en     = 1'b0;
    repeat (2) @(posedge clk);
    reset_dut();

    // PASS, single byte, one-cycle latency
    step(1'b1, 8'h41, 1'b1, 2'd0);
    #1;
    chk("pass_lat_vld", bus.tx_valid, 1'b1);
    chk("pass_lat_dat", bus.tx_data, 8'h41);
    step(1'b0, 8'h00, 1'b1, 2'd0);
    chk_log("pass_out", 32'h41, 1);

    // CASE_SWAP "aZ5"
    step(1'b1, 8'h61, 1'b1, 2'd1);
    step(1'b1, 8'h5A, 1'b1, 2'd1);
    step(1'b1, 8'h35, 1'b1, 2'd1);
    repeat (3) step(1'b0, 8'h00, 1'b1, 2'd1);
    chk_log("swap_out", 32'h417A35, 3);

    // LINE "hi\r"
    reset_dut();
    step(1'b1, 8'h68, 1'b1, 2'd2);
    step(1'b1, 8'h69, 1'b1, 2'd2);
    step(1'b1, 8'h0D, 1'b1, 2'd2);
    repeat (4) step(1'b0, 8'h00, 1'b1, 2'd2);
    chk_log("line_out", 32'h68690D, 3);
    chk("line_cnt", line_count, 16'd1);

    // LINE forced flush on full buffer, no CR
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 2'd2);
    step(1'b1, 8'h77, 1'b0, 2'd2);
    repeat (DEPTH + 1) step(1'b0, 8'h00, 1'b1, 2'd2);
    chk_log("flush_out", 32'h30313233, 4);

    // PASS stall with full buffer, then drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 2'd0);
    repeat (3) step(1'b1, 8'h55, 1'b0, 2'd0);
    chk("stall_full_cnt", fifo_count, DEPTH);
    repeat (DEPTH + 1) step(1'b0, 8'h00, 1'b1, 2'd0);
    chk_log("stall_out", 32'hA0A1A2A3, 4);

    // reset with bytes buffered
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 2'd0);
    reset_dut();
    repeat (4) step(1'b0, 8'h00, 1'b1, 2'd0);
    chk("rst_no_stale", out_log.size(), 0);
    out_log.delete();

    // randomized traffic, mode changes and occasional resets
    md = 2'd0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) reset_dut();
      b = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom);
      step(1'($urandom_range(0, 2) != 0), b, 1'($urandom_range(0, 2) != 0), md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
